next_pc_predictor: RTL
======================

// Module: next_pc_predictor
// PURPOSE
//   Next-PC generator directly upstream of the PC register: drives its pc_i each cycle.
//   Direct-mapped branch target buffer (BTB) with 2-bit saturating counters predicts taken branches at fetch.
//   Branch resolution in ID trains the BTB and redirects fetch on mispredict.
//   Also raises the IF/ID flush request and keeps branch/mispredict performance counters.
// PARAMETERS
//   ENTRIES  16  BTB entries; power of 2, >=2. IDX_W = log2(ENTRIES).
//   CNT_W    32  width of the performance counters.
// PORTS
//   clk_i            in   1       clock, rising edge
//   rst_i            in   1       synchronous reset, active-high
//   pc_i             in   32      current fetch PC (PC register output)
//   stall_i          in   1       hazard stall (same signal that holds PC)
//   res_valid_i      in   1       ID stage holds a resolved branch/jump this cycle
//   res_pc_i         in   32      PC of the resolved instruction
//   res_taken_i      in   1       actual direction (1 = taken; jumps always 1)
//   res_target_i     in   32      actual taken target
//   res_pred_next_i  in   32      next PC predicted when this instruction was fetched (carried IF->ID)
//   next_pc_o        out  32      value for the PC register's pc_i
//   pred_taken_o     out  1       BTB predicted taken for pc_i (goes into IF/ID)
//   flush_o          out  1       mispredict: squash the IF/ID entry
//   br_cnt_o         out  CNT_W   resolved-branch count
//   miss_cnt_o       out  CNT_W   mispredict count
// BEHAVIOUR
//   Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. Entry = {valid, tag, target[31:0], ctr[1:0]}.
//   Lookup is combinational on pc_i.
//     hit = valid && (tag == pc_i tag).
//     pred_taken_o = hit && ctr[1].
//     Predicted next = pred_taken_o ? target : pc_i + 4 (mod 2^32, wraps).
//   Resolution is combinational.
//     act_next = res_taken_i ? res_target_i : res_pc_i + 4.
//     mispredict = res_valid_i && !stall_i && (act_next != res_pred_next_i).
//   Outputs:
//     next_pc_o = mispredict ? act_next : predicted next. Mispredict has priority.
//     flush_o = mispredict. Zero-cycle latency for both.
//   Training happens at posedge when res_valid_i && !stall_i, indexed by res_pc_i:
//     - Hit: ctr increments if taken, decrements if not taken, saturating at 3 and 0.
//       If taken, target <= res_target_i.
//     - Miss and taken: allocate (overwrite). valid=1, tag, target=res_target_i, ctr=2'b10.
//     - Miss and not taken: no write.
//   Writes are visible to lookups from the next cycle only (no write-to-read bypass).
//     A same-cycle lookup at the same index reads the old entry.
//   stall_i=1 suppresses training, counter updates and flush_o.
//     next_pc_o still shows the prediction; PC ignores it while stalled.
//   Perf counters, when res_valid_i && !stall_i:
//     - br_cnt_o += 1.
//     - miss_cnt_o += mispredict.
//     - Both saturate at all-ones; no wrap.
//   Reset (sync, rst_i=1 at posedge):
//     - All valid=0, all ctr=2'b01, br_cnt_o=miss_cnt_o=0.
//     - Resolution inputs are ignored in the reset cycle.
//     - After reset: pred_taken_o=0, next_pc_o=pc_i+4, flush_o=0 unless a mispredict is presented.
//   Reset mid-operation discards any in-flight training. Target/tag contents after reset are don't-care.
//   Aliasing: different PCs with the same index evict each other. The tag compare prevents false hits.
// TESTING
//   1. After reset, pc_i=0x0000_0040 -> next_pc_o=0x0000_0044, pred_taken_o=0, flush_o=0, both counters 0.
//   2. Taken-miss training:
//      - Stimulus: res_valid_i=1, res_pc_i=0x100, taken, target=0x200, pred_next=0x104.
//      - Same cycle: flush_o=1, next_pc_o=0x200.
//      - Next cycle, pc_i=0x100: pred_taken_o=1, next_pc_o=0x200.
//      - miss_cnt_o=1, br_cnt_o=1.
//   3. Counter hysteresis:
//      - From test 2 (ctr=2): one not-taken resolve -> ctr=1, pc_i=0x100 predicts 0x104.
//      - Two taken resolves -> ctr=3; one not-taken -> still predicts 0x200.
//   4. Alias: after test 2, pc_i=0x140 (same index at ENTRIES=16, different tag) -> pred_taken_o=0, next_pc_o=0x144.
//   5. stall_i=1 with a mispredicting resolve -> flush_o=0, no BTB write, counters unchanged.
//      - Same resolve with stall_i=0 next cycle -> flush_o=1.
//   6. Wrap and saturation:
//      - pc_i=0xFFFF_FFFC, no hit -> next_pc_o=0x0000_0000.
//      - With CNT_W=4: 16 resolves -> br_cnt_o stays 4'hF.
//      - rst_i mid-stream -> counters 0, previously trained PC no longer hits.

Source files
------------

// File: rtl/next_pc_predictor.sv
// Next-PC generator: direct-mapped BTB with 2-bit saturating counters,
// branch-resolution redirect/flush and saturating branch/mispredict counters.
module next_pc_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_i,
  input  logic             stall_i,
  input  logic             res_valid_i,
  input  logic [31:0]      res_pc_i,
  input  logic             res_taken_i,
  input  logic [31:0]      res_target_i,
  input  logic [31:0]      res_pred_next_i,
  output logic [31:0]      next_pc_o,
  output logic             pred_taken_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t       btb_q [ENTRIES];
  btb_entry_t       btb_d [ENTRIES];
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  btb_entry_t       f_ent, r_ent;
  logic             f_hit, r_hit;
  logic [31:0]      pred_next, act_next;
  logic             train, mispredict;

  // Fetch-side lookup and resolution compare; mispredict redirect wins
  always_comb begin
    f_idx        = pc_i[IDX_W+1:2];
    f_tag        = pc_i[31:IDX_W+2];
    f_ent        = btb_q[f_idx];
    f_hit        = f_ent.valid && (f_ent.tag == f_tag);
    pred_taken_o = f_hit && f_ent.ctr[1];
    pred_next    = pred_taken_o ? f_ent.target : pc_i + 32'd4;
    act_next     = res_taken_i ? res_target_i : res_pc_i + 32'd4;
    train        = res_valid_i && !stall_i;
    mispredict   = train && (act_next != res_pred_next_i);
    next_pc_o    = mispredict ? act_next : pred_next;
    flush_o      = mispredict;
  end

  // BTB training: update counter/target on hit, allocate on taken miss
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) btb_d[i] = btb_q[i];
    r_idx = res_pc_i[IDX_W+1:2];
    r_tag = res_pc_i[31:IDX_W+2];
    r_ent = btb_q[r_idx];
    r_hit = r_ent.valid && (r_ent.tag == r_tag);
    if (train) begin
      if (r_hit) begin
        if (res_taken_i) begin
          if (r_ent.ctr != 2'b11) r_ent.ctr = r_ent.ctr + 2'b01;
          r_ent.target = res_target_i;
        end else if (r_ent.ctr != 2'b00) begin
          r_ent.ctr = r_ent.ctr - 2'b01;
        end
        btb_d[r_idx] = r_ent;
      end else if (res_taken_i) begin
        btb_d[r_idx] = '{valid: 1'b1, tag: r_tag, target: res_target_i, ctr: 2'b10};
      end
    end
  end

  // Saturating performance counters
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (train && (br_cnt_q != '1))        br_cnt_d   = br_cnt_q + CNT_W'(1);
    if (mispredict && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
  end

  // State registers; reset clears valids, weak-not-taken counters, perf counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= btb_d[i];
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign br_cnt_o   = br_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule
